seq_det_param: RTL and testbench

SEQ_DET_PARAM -- requirements
Module: seq_det_param

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/seq_det_param_if.sv | 37 +++
 rtl/seq_det_param_sat_counter.sv | 45 ++++
 rtl/seq_det_param.sv | 94 +++++++++
 tb/tb_seq_det_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_det_pkg                                            |
// | Brief   : Shared state encoding, default widths and helpers for  |
// |           the parameterised serial sequence detector.            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package seq_det_pkg;

  // Default geometry of the detector.
  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT_RST = 4'b1011;

  // FILL: fewer than PAT_W valid bits in the history; ARMED: window full.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Width needed to hold a fill count in the range 0..pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_det_param_if                                       |
// | Brief   : Serial data, pattern control and status signals of the |
// |           sequence detector. The master drives the stimulus side |
// |           and the slave (detector) returns match status.         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface seq_det_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             x;          // serial data bit
  logic             x_valid;    // x is sampled only when high
  logic [PAT_W-1:0] pat_in;     // new pattern, first-received bit at MSB
  logic             pat_load;   // load pat_in and restart filling
  logic             ovl_en;     // 1 = overlapping, 0 = non-overlapping
  logic             cnt_clr;    // clear the match counter
  logic             z;          // one-cycle registered match pulse
  logic [CNT_W-1:0] match_cnt;  // saturating match count
  logic             armed;      // history holds PAT_W valid bits

  modport master (
    output x, x_valid, pat_in, pat_load, ovl_en, cnt_clr,
    input  z, match_cnt, armed
  );

  modport slave (
    input  x, x_valid, pat_in, pat_load, ovl_en, cnt_clr,
    output z, match_cnt, armed
  );

endinterface : seq_det_param_if
`default_nettype wire

// File: rtl/seq_det_param_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sat_counter                                            |
// | Brief   : Up-counter that saturates at all-ones; clear wins over |
// |           a simultaneous increment.                              |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then saturating increment, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_det_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_det_param                                          |
// | Brief   : Programmable serial pattern detector with overlapping  |
// |           or non-overlapping matching, a registered match pulse  |
// |           and a saturating match counter.                        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  seq_det_param_if.slave   bus
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  // The oldest bit of the window leaves the history on the very edge
  // that completes it, so the stored history only needs the PAT_W-1
  // most recent bits; the full window is {hist_q, x}.
  state_t             state_q;
  logic [PAT_W-2:0]   hist_q;
  logic [PAT_W-1:0]   pat_q;
  logic [FILL_W-1:0]  fill_q;
  logic               z_q;

  logic               accept_d;
  logic [PAT_W-1:0]   window_d;
  logic [FILL_W-1:0]  fill_d;
  logic               match_d;
  logic [CNT_W-1:0]   cnt_d;

  // Shifted window, saturating fill and match decision for this edge.
  always_comb begin
    accept_d = bus.x_valid & ~bus.pat_load;
    window_d = {hist_q, bus.x};
    fill_d   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    match_d  = accept_d && (fill_d == FILL_FULL) && (window_d == pat_q);
  end

  // Detector FSM: history, fill count, pattern and registered pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_FILL;
      z_q     <= 1'b0;
    end else if (bus.pat_load) begin
      // A bit presented alongside a load is discarded; the history
      // contents are irrelevant once fill restarts from zero.
      pat_q   <= bus.pat_in;
      fill_q  <= '0;
      state_q <= ST_FILL;
      z_q     <= 1'b0;
    end else if (accept_d) begin
      hist_q <= window_d[PAT_W-2:0];
      z_q    <= match_d;
      if (match_d && !bus.ovl_en) begin
        // Non-overlapping: the matched bits cannot be reused.
        fill_q  <= '0;
        state_q <= ST_FILL;
      end else begin
        fill_q  <= fill_d;
        state_q <= (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
      end
    end else begin
      // Idle cycle: hold everything, pulse ends.
      z_q <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .clr   (bus.cnt_clr),
    .cnt   (cnt_d)
  );

  assign bus.z         = z_q;
  assign bus.armed     = (state_q == ST_ARMED);
  assign bus.match_cnt = cnt_d;

endmodule : seq_det_param
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_seq_det_param                                       |
// | Brief   : Directed and random stimulus for seq_det_param, scored |
// |           against a bit-queue reference model.                   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_seq_det_param;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_param_if #(.PAT_W(4), .CNT_W(8)) ifa ();
  seq_det_param_if #(.PAT_W(2), .CNT_W(2)) ifb ();

  seq_det_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  seq_det_param #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  // Reference model for dut_a: the accepted bits since the last restart,
  // oldest first, capped at the pattern length.
  bit         hq[$];
  logic [3:0] m_pat;
  int         m_cnt;
  logic       m_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_a(input bit rst, input bit ld, input logic [3:0] pin,
                         input bit xv, input bit xb, input bit ov, input bit clr);
    bit hit;
    hit = 1'b0;
    if (rst) begin
      m_pat = 4'b1011;
      hq.delete();
      m_cnt = 0;
    end else begin
      if (ld) begin
        m_pat = pin;
        hq.delete();
      end else if (xv) begin
        hq.push_back(xb);
        if (hq.size() > 4) void'(hq.pop_front());
        if (hq.size() == 4) begin
          hit = 1'b1;
          for (int i = 0; i < 4; i++)
            if (hq[i] != m_pat[3-i]) hit = 1'b0;
        end
        if (hit && !ov) hq.delete();
      end
      if (clr) m_cnt = 0;
      else if (hit) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    m_z = hit;
  endtask

  task automatic step_a(input bit rst, input bit ld, input logic [3:0] pin,
                        input bit xv, input bit xb, input bit ov, input bit clr);
    rst_a        = rst;
    ifa.pat_load = ld;
    ifa.pat_in   = pin;
    ifa.x_valid  = xv;
    ifa.x        = xb;
    ifa.ovl_en   = ov;
    ifa.cnt_clr  = clr;
    @(posedge clk);
    model_a(rst, ld, pin, xv, xb, ov, clr);
    #1;
    chk("a_z", 32'(ifa.z), 32'(m_z));
    chk("a_cnt", 32'(ifa.match_cnt), 32'(m_cnt));
    chk("a_armed", 32'(ifa.armed), 32'(hq.size() == 4));
  endtask

  task automatic bit_a(input bit xb, input bit ov);
    step_a(1'b0, 1'b0, 4'h0, 1'b1, xb, ov, 1'b0);
  endtask

  task automatic gap_a(input bit ov);
    step_a(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ov, 1'b0);
  endtask

  task automatic step_b(input bit rst, input bit xv, input bit xb, input bit clr,
                        input bit exp_z, input logic [1:0] exp_cnt, input string tag);
    rst_b       = rst;
    ifb.x_valid = xv;
    ifb.x       = xb;
    ifb.cnt_clr = clr;
    @(posedge clk);
    #1;
    chk({tag, "_z"}, 32'(ifb.z), 32'(exp_z));
    chk({tag, "_cnt"}, 32'(ifb.match_cnt), 32'(exp_cnt));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [3:0] s;
    ifa.x = 1'b0; ifa.x_valid = 1'b0; ifa.pat_in = '0;
    ifa.pat_load = 1'b0; ifa.ovl_en = 1'b0; ifa.cnt_clr = 1'b0;
    ifb.x = 1'b0; ifb.x_valid = 1'b0; ifb.pat_in = '0;
    ifb.pat_load = 1'b0; ifb.ovl_en = 1'b1; ifb.cnt_clr = 1'b0;
    m_pat = 4'b1011; m_cnt = 0; m_z = 1'b0;

    // Reset state.
    step_a(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_z", 32'(ifa.z), 0);
    chk("rst_cnt", 32'(ifa.match_cnt), 0);
    chk("rst_armed", 32'(ifa.armed), 0);

    // Overlapping detection of 1011 in 1,0,1,1,0,1,1.
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) bit_a(s[i], 1'b1);
    chk("ovl_z_bit4", 32'(ifa.z), 1);
    bit_a(1'b0, 1'b1);
    bit_a(1'b1, 1'b1);
    bit_a(1'b1, 1'b1);
    chk("ovl_z_bit7", 32'(ifa.z), 1);
    chk("ovl_cnt", 32'(ifa.match_cnt), 2);

    // Non-overlapping: same stream gives a single match.
    step_a(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) bit_a(s[i], 1'b0);
    chk("novl_z_bit4", 32'(ifa.z), 1);
    bit_a(1'b0, 1'b0);
    bit_a(1'b1, 1'b0);
    bit_a(1'b1, 1'b0);
    chk("novl_z_bit7", 32'(ifa.z), 0);
    chk("novl_cnt", 32'(ifa.match_cnt), 1);
    chk("novl_armed", 32'(ifa.armed), 0);

    // Reload 0110 with a same-cycle bit that must be discarded.
    step_a(1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_armed", 32'(ifa.armed), 0);
    bit_a(1'b0, 1'b0);
    bit_a(1'b1, 1'b0);
    bit_a(1'b1, 1'b0);
    chk("load_z_bit3", 32'(ifa.z), 0);
    bit_a(1'b0, 1'b0);
    chk("load_z_bit4", 32'(ifa.z), 1);
    chk("load_cnt", 32'(ifa.match_cnt), 2);

    // Gaps never break a match; reset before the final bit aborts it.
    step_a(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1, 1'b0); gap_a(1'b1);
    bit_a(1'b0, 1'b0); gap_a(1'b0); gap_a(1'b1);
    bit_a(1'b1, 1'b0); gap_a(1'b0);
    bit_a(1'b1, 1'b0);
    chk("gap_z", 32'(ifa.z), 1);
    gap_a(1'b0);
    chk("gap_z_drop", 32'(ifa.z), 0);
    step_a(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1, 1'b0); gap_a(1'b0);
    bit_a(1'b0, 1'b0); gap_a(1'b0);
    bit_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1, 1'b0);
    chk("abort_z", 32'(ifa.z), 0);
    chk("abort_cnt", 32'(ifa.match_cnt), 0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step_a($urandom_range(0, 99) < 1,
             $urandom_range(0, 99) < 4,
             4'($urandom_range(0, 15)),
             $urandom_range(0, 99) < 75,
             1'($urandom),
             1'($urandom),
             $urandom_range(0, 99) < 3);
    end

    // Saturation and clear on the 2-bit counter instance, pattern 11.
    step_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "b_rst");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "b_bit1");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "b_bit2");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, "b_bit3");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, "b_bit4");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, "b_bit5");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, "b_bit6");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, "b_bit7");
    step_b(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, "b_clr_match");
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "b_after_clr");
    step_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, "b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_det_param
`default_nettype wire
